firebird7_in_gate1_secure_scanmux_ctrl: RTL and testbench
=========================================================

Name: firebird7_in_gate1_secure_scanmux_ctrl

Overview:
- IJTAG-side controller that produces the `mux_select` bit consumed by the gate1 secure spare scan mux.
- It is one IJTAG data-register segment {sib_bit, key[KEY_W-1:0]}. Its shift, capture and update operations open or close the spare scan path.
- The path can open only after a correct key is shifted in and updated.
- It sits on the gate1 IJTAG chain directly in front of the secure mux.

Parameters:
- KEY_W, 8: key field width; must be >= FAIL_W+2.
- KEY_VALUE, 8'hA5: unlock key compared at update.
- MAX_FAILS, 3: mismatch count that triggers lockout (feature build only).
- FAIL_W, 2: fail counter width; must satisfy 2**FAIL_W-1 >= MAX_FAILS.

Ports:
- ijtag_tck  in  1  clock; all state changes on the rising edge
- ijtag_reset  in  1  synchronous, active-high reset
- ijtag_sel  in  1  segment selected
- ijtag_se  in  1  shift enable
- ijtag_ce  in  1  capture enable
- ijtag_ue  in  1  update enable
- ijtag_si  in  1  scan in
- ijtag_so  out  1  scan out = sr[0]
- mux_select  out  1  registered select to the secure mux
- unlocked  out  1  high when FSM state is UNLOCKED
- locked_out  out  1  high when FSM state is LOCKOUT (tied 0 without the feature)

Behaviour:
- Registers:
  - sr[KEY_W:0] shift register; sr[KEY_W] is the sib_bit.
  - mux_select.
  - state[1:0]: LOCKED=0, UNLOCKED=1, LOCKOUT=2.
  - fail_cnt[FAIL_W-1:0].
- Reset, when ijtag_reset is high at the edge:
  - sr=0, mux_select=0, state=LOCKED, fail_cnt=0.
  - ijtag_so=0, unlocked=0, locked_out=0.
  - Reset wins over every other input, including mid-shift.
- Operations are qualified by ijtag_sel. Priority is se > ce > ue; only the highest-priority asserted enable acts. With sel=0, all registers hold.
- Shift (sel&se):
  - sr <= {ijtag_si, sr[KEY_W:1]}; LSB-first out, sib_bit enters last.
  - One bit per cycle. Shift alone never changes mux_select, state or fail_cnt.
- Capture (sel&ce&!se):
  - sr[KEY_W]=mux_select, sr[1:0]=state, sr[FAIL_W+1:2]=fail_cnt, all other bits 0.
  - The key is never captured.
- Update (sel&ue&!se&!ce); let match = (sr[KEY_W-1:0]==KEY_VALUE):
  - LOCKED & match: state->UNLOCKED, fail_cnt<=0, mux_select<=sr[KEY_W].
  - LOCKED & !match: mux_select stays 0; fail_cnt increments, saturating at all-ones.
  - UNLOCKED & match: mux_select<=sr[KEY_W].
  - UNLOCKED & !match: state->LOCKED, mux_select<=0; fail_cnt unchanged.
  - LOCKOUT: all updates ignored; mux_select stays 0.
- Latency:
  - mux_select, unlocked and locked_out are visible the cycle after the update edge.
  - ijtag_so reflects the new sr one cycle after a shift or capture edge.
- Invariant: mux_select=1 implies state==UNLOCKED, in every cycle.

Optional Feature:
- Macro: SECURE_SCANMUX_LOCKOUT_EN.
- Defined: a LOCKED & !match update that brings fail_cnt to MAX_FAILS moves state to LOCKOUT and sets locked_out=1. LOCKOUT exits only on ijtag_reset. Capture reports state=2.
- Undefined: there is no LOCKOUT state and locked_out is tied to 0. fail_cnt saturates and is informational only; unlimited retries are allowed.

Decomposition:
- Package firebird7_in_gate1_secure_scanmux_pkg holds:
  - the state enum typedef (LOCKED/UNLOCKED/LOCKOUT, 2 bits);
  - capture field-offset localparams (STATE_LSB=0, FAIL_LSB=2);
  - the default KEY_W and KEY_VALUE.
- One sub-module is natural: firebird7_in_gate1_secure_scanmux_dr. It holds the shift/capture register and scan-out. The FSM, key compare and mux_select logic stay in the top.

Test Plan:
1. Reset check: assert ijtag_reset for 2 cycles mid-shift -> all outputs 0, state LOCKED; a following capture then 9 shifts yields 0x000.
2. Correct unlock: shift {1,8'hA5} LSB-first over 9 cycles, then ue=1 -> next cycle mux_select=1, unlocked=1.
3. Secure capture: after scenario 2, capture and shift out 9 bits -> sr=0x101 (sib=1, state=1, fail=0); the A5 key is never seen on ijtag_so.
4. Wrong key: shift {1,8'h3C} and update -> mux_select stays 0 and fail_cnt=1; capture shows 0x004.
5. Relock: from UNLOCKED with mux_select=1, update with key 8'h00 -> mux_select=0, state LOCKED next cycle.
6. With SECURE_SCANMUX_LOCKOUT_EN defined:
   - 3 wrong-key updates -> locked_out=1.
   - A subsequent correct key {1,8'hA5} update leaves mux_select=0.
   - ijtag_reset clears locked_out to 0.
   - With the macro undefined, the same sequence unlocks normally.

Source files
------------

// File: rtl/firebird7_in_gate1_secure_scanmux_pkg.sv
// Shared types and constants for the gate1 secure scan-mux IJTAG controller.
package firebird7_in_gate1_secure_scanmux_pkg;

    typedef enum logic [1:0] {
        StLocked   = 2'd0,
        StUnlocked = 2'd1,
        StLockout  = 2'd2
    } state_e;

    // Bit offsets of the status fields inside the captured DR image.
    localparam int unsigned STATE_LSB = 0;
    localparam int unsigned FAIL_LSB  = 2;

    localparam int unsigned KEY_W_DEFAULT     = 8;
    localparam logic [7:0]  KEY_VALUE_DEFAULT = 8'hA5;

endpackage

// File: rtl/firebird7_in_gate1_secure_scanmux_dr.sv
// IJTAG data register {sib_bit, key}: serial shift, parallel status capture, scan-out.
module firebird7_in_gate1_secure_scanmux_dr #(
    parameter int unsigned KEY_W = 8
) (
    input  logic             tck,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             capture_en,
    input  logic             si,
    input  logic [KEY_W:0]   capture_data,
    output logic [KEY_W:0]   sr,
    output logic             so
);

    logic [KEY_W:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (shift_en) begin
            // LSB leaves first; the sib bit is the last one to enter.
            sr_d = {si, sr_q[KEY_W:1]};
        end else if (capture_en) begin
            sr_d = capture_data;
        end
    end

    always_ff @(posedge tck) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr = sr_q;
    assign so = sr_q[0];

endmodule

// File: rtl/firebird7_in_gate1_secure_scanmux_ctrl.sv
// Key-gated controller driving mux_select of the gate1 secure spare scan mux.
// Optional lockout after repeated bad keys: define SECURE_SCANMUX_LOCKOUT_EN.
module firebird7_in_gate1_secure_scanmux_ctrl
    import firebird7_in_gate1_secure_scanmux_pkg::*;
#(
    parameter int unsigned      KEY_W     = KEY_W_DEFAULT,
    parameter logic [KEY_W-1:0] KEY_VALUE = KEY_VALUE_DEFAULT,
    parameter int unsigned      MAX_FAILS = 3,
    parameter int unsigned      FAIL_W    = 2
) (
    input  logic ijtag_tck,
    input  logic ijtag_reset,
    input  logic ijtag_sel,
    input  logic ijtag_se,
    input  logic ijtag_ce,
    input  logic ijtag_ue,
    input  logic ijtag_si,
    output logic ijtag_so,
    output logic mux_select,
    output logic unlocked,
    output logic locked_out
);

    // Status fields must fit below the sib bit, and the counter must reach the limit.
    if (KEY_W < FAIL_W + 2) begin : gen_bad_key_w
        $error("KEY_W must be >= FAIL_W+2");
    end
    if (MAX_FAILS > (2 ** FAIL_W) - 1) begin : gen_bad_fail_w
        $error("FAIL_W too narrow for MAX_FAILS");
    end

    state_e              state_q, state_d;
    logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic                mux_select_q, mux_select_d;
    logic [KEY_W:0]      sr;
    logic [KEY_W:0]      capture_data;
    logic                do_shift, do_capture, do_update, key_match;

    assign do_shift   = ijtag_sel & ijtag_se;
    assign do_capture = ijtag_sel & ijtag_ce & ~ijtag_se;
    assign do_update  = ijtag_sel & ijtag_ue & ~ijtag_se & ~ijtag_ce;
    assign key_match  = (sr[KEY_W-1:0] == KEY_VALUE);

    // Status only; the key field is deliberately never reflected back.
    always_comb begin
        capture_data                          = '0;
        capture_data[KEY_W]                   = mux_select_q;
        capture_data[STATE_LSB +: 2]          = state_q;
        capture_data[FAIL_LSB +: FAIL_W]      = fail_cnt_q;
    end

    firebird7_in_gate1_secure_scanmux_dr #(
        .KEY_W (KEY_W)
    ) u_dr (
        .tck          (ijtag_tck),
        .reset        (ijtag_reset),
        .shift_en     (do_shift),
        .capture_en   (do_capture),
        .si           (ijtag_si),
        .capture_data (capture_data),
        .sr           (sr),
        .so           (ijtag_so)
    );

    always_comb begin
        state_d      = state_q;
        fail_cnt_d   = fail_cnt_q;
        mux_select_d = mux_select_q;
        unique case (state_q)
            StLocked: begin
                mux_select_d = 1'b0;
                if (do_update) begin
                    if (key_match) begin
                        state_d      = StUnlocked;
                        fail_cnt_d   = '0;
                        mux_select_d = sr[KEY_W];
                    end else begin
                        if (fail_cnt_q != '1) begin
                            fail_cnt_d = fail_cnt_q + FAIL_W'(1);
                        end
`ifdef SECURE_SCANMUX_LOCKOUT_EN
                        if (fail_cnt_d == FAIL_W'(MAX_FAILS)) begin
                            state_d = StLockout;
                        end
`endif
                    end
                end
            end
            StUnlocked: begin
                if (do_update) begin
                    if (key_match) begin
                        mux_select_d = sr[KEY_W];
                    end else begin
                        state_d      = StLocked;
                        mux_select_d = 1'b0;
                    end
                end
            end
`ifdef SECURE_SCANMUX_LOCKOUT_EN
            StLockout: begin
                mux_select_d = 1'b0;
            end
`endif
            default: begin
                state_d      = StLocked;
                mux_select_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            state_q      <= StLocked;
            fail_cnt_q   <= '0;
            mux_select_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fail_cnt_q   <= fail_cnt_d;
            mux_select_q <= mux_select_d;
        end
    end

    assign mux_select = mux_select_q;
    assign unlocked   = (state_q == StUnlocked);
`ifdef SECURE_SCANMUX_LOCKOUT_EN
    assign locked_out = (state_q == StLockout);
`else
    assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_firebird7_in_gate1_secure_scanmux_ctrl.sv
// Directed self-checking bench for the gate1 secure scan-mux controller.
module tb_firebird7_in_gate1_secure_scanmux_ctrl;

    logic tck = 1'b0;
    logic reset, sel, se, ce, ue, si;
    logic so, mux_select, unlocked, locked_out;
    logic [8:0] dr_val;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 tck = ~tck;

    firebird7_in_gate1_secure_scanmux_ctrl dut (
        .ijtag_tck   (tck),
        .ijtag_reset (reset),
        .ijtag_sel   (sel),
        .ijtag_se    (se),
        .ijtag_ce    (ce),
        .ijtag_ue    (ue),
        .ijtag_si    (si),
        .ijtag_so    (so),
        .mux_select  (mux_select),
        .unlocked    (unlocked),
        .locked_out  (locked_out)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic shift_word(input logic [8:0] w);
        sel = 1'b1;
        se  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            si = w[i];
            tick();
        end
        se = 1'b0;
        si = 1'b0;
    endtask

    task automatic do_update();
        sel = 1'b1;
        ue  = 1'b1;
        tick();
        ue  = 1'b0;
    endtask

    task automatic read_dr(output logic [8:0] v);
        sel = 1'b1;
        ce  = 1'b1;
        tick();
        ce  = 1'b0;
        se  = 1'b1;
        si  = 1'b0;
        for (int i = 0; i < 9; i++) begin
            v[i] = so;
            tick();
        end
        se = 1'b0;
    endtask

    // mux_select may only be high while unlocked.
    always @(negedge tck) begin
        if (reset === 1'b0) begin
            n_checks++;
            assert (!(mux_select === 1'b1 && unlocked !== 1'b1)) else begin
                n_fail++;
                $error("FAIL invariant: mux_select %b unlocked %b", mux_select, unlocked);
            end
        end
    end

    initial begin
        reset = 1'b1; sel = 1'b0; se = 1'b0; ce = 1'b0; ue = 1'b0; si = 1'b0;
        tick();
        reset = 1'b0;

        // Reset in the middle of a shift.
        sel = 1'b1; se = 1'b1; si = 1'b1;
        tick(); tick(); tick();
        reset = 1'b1;
        tick(); tick();
        check("reset_so", {15'd0, so}, 16'd0);
        check("reset_mux", {15'd0, mux_select}, 16'd0);
        check("reset_unlocked", {15'd0, unlocked}, 16'd0);
        check("reset_locked_out", {15'd0, locked_out}, 16'd0);
        reset = 1'b0; se = 1'b0; si = 1'b0;
        read_dr(dr_val);
        check("reset_capture", {7'd0, dr_val}, 16'h000);

        // Correct unlock.
        shift_word(9'h1A5);
        do_update();
        check("unlock_mux", {15'd0, mux_select}, 16'd1);
        check("unlock_unlocked", {15'd0, unlocked}, 16'd1);
        check("unlock_locked_out", {15'd0, locked_out}, 16'd0);

        // Secure capture: status only, no key.
        read_dr(dr_val);
        check("secure_capture", {7'd0, dr_val}, 16'h101);

        // sel=0 holds everything even with all enables asserted.
        sel = 1'b0; se = 1'b1; ce = 1'b1; ue = 1'b1;
        tick(); tick();
        se = 1'b0; ce = 1'b0; ue = 1'b0;
        check("nosel_mux", {15'd0, mux_select}, 16'd1);

        // Relock with a bad key.
        shift_word(9'h100);
        do_update();
        check("relock_mux", {15'd0, mux_select}, 16'd0);
        check("relock_unlocked", {15'd0, unlocked}, 16'd0);
        read_dr(dr_val);
        check("relock_capture", {7'd0, dr_val}, 16'h000);

        // se outranks ue: correct key in sr, but update must not act while shifting.
        shift_word(9'h1A5);
        sel = 1'b1; se = 1'b1; ue = 1'b1; si = 1'b0;
        tick();
        se = 1'b0; ue = 1'b0;
        check("prio_se_ue", {15'd0, unlocked}, 16'd0);
        // ce outranks ue.
        shift_word(9'h1A5);
        ce = 1'b1; ue = 1'b1;
        tick();
        ce = 1'b0; ue = 1'b0;
        check("prio_ce_ue", {15'd0, unlocked}, 16'd0);

        // Wrong key.
        shift_word(9'h13C);
        do_update();
        check("wrong_mux", {15'd0, mux_select}, 16'd0);
        read_dr(dr_val);
        check("wrong_capture", {7'd0, dr_val}, 16'h004);

        // Two more wrong keys reach the fail limit.
        shift_word(9'h13C);
        do_update();
        shift_word(9'h1FF);
        do_update();
`ifdef SECURE_SCANMUX_LOCKOUT_EN
        check("lockout_flag", {15'd0, locked_out}, 16'd1);
        read_dr(dr_val);
        check("lockout_capture", {7'd0, dr_val}, 16'h00E);
`else
        check("lockout_flag", {15'd0, locked_out}, 16'd0);
        read_dr(dr_val);
        check("lockout_capture", {7'd0, dr_val}, 16'h00C);
`endif

        // Correct key after the failures.
        shift_word(9'h1A5);
        do_update();
`ifdef SECURE_SCANMUX_LOCKOUT_EN
        check("post_lock_mux", {15'd0, mux_select}, 16'd0);
        check("post_lock_unlocked", {15'd0, unlocked}, 16'd0);
`else
        check("post_lock_mux", {15'd0, mux_select}, 16'd1);
        check("post_lock_unlocked", {15'd0, unlocked}, 16'd1);
        read_dr(dr_val);
        check("post_lock_capture", {7'd0, dr_val}, 16'h101);
`endif

        // Reset clears everything, including lockout.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("final_reset_locked_out", {15'd0, locked_out}, 16'd0);
        check("final_reset_mux", {15'd0, mux_select}, 16'd0);
        read_dr(dr_val);
        check("final_reset_capture", {7'd0, dr_val}, 16'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
